obi_read_manager: RTL

- Synthesizable OBI read initiator (manager).
- Takes a burst command (start address, word count) and issues one OBI read per word, incrementing the word-aligned address each time.
- Keeps up to MaxOutstanding reads in flight and returns read data in order on a valid/ready stream.
- Counterpart of the testbench OBI read responder; used to drive OBI read subordinates in the DMA backend and its benches.

---
 rtl/obi_read_manager.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/obi_read_manager.sv
// OBI read manager: turns a (start address, word count) command into a train of
// word reads, keeps a bounded number in flight and streams the data back in order.
module obi_read_manager #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LenWidth       = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [LenWidth-1:0]    cmd_len_i,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  input  logic                   obi_rvalid_i,
  output logic                   obi_rready_o,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic [DataWidth-1:0]   data_o,
  output logic                   data_last_o,
  output logic                   data_err_o,
  output logic                   busy_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned OffWidth = $clog2(BeWidth);
  localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
  localparam int unsigned CntWidth = PtrWidth + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [LenWidth-1:0]   len_q;
  logic [LenWidth-1:0]   remaining;
  logic [LenWidth-1:0]   rsp_cnt;
  logic [CntWidth-1:0]   credit;
  logic [CntWidth-1:0]   credit_nxt;
  logic [CntWidth-1:0]   fifo_cnt;
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [DataWidth-1:0]  mem_data [MaxOutstanding];
  logic                  mem_err  [MaxOutstanding];
  logic                  mem_last [MaxOutstanding];
  logic                  grant;
  logic                  pop;
  logic                  push;
  logic                  can_issue;
  logic                  rsp_last;
  logic                  addr_lsb_unused;

  assign addr_lsb_unused = ^cmd_addr_i[OffWidth-1:0];

  assign obi_we_o = 1'b0;
  assign obi_be_o = '1;

  assign grant = obi_req_o & obi_gnt_i;
  assign pop   = data_valid_o & data_ready_i;
  // Responses outside a command belong to an abandoned burst and are dropped.
  assign push  = obi_rvalid_i & obi_rready_o & (state != IDLE);

  // Credit = granted reads whose beat has not yet left the output stream.
  assign credit_nxt = credit + CntWidth'(grant) - CntWidth'(pop);
  assign can_issue  = credit_nxt < CntWidth'(MaxOutstanding);
  assign rsp_last   = (rsp_cnt == len_q - LenWidth'(1));

  assign data_valid_o = (fifo_cnt != '0);
  assign data_o       = data_valid_o ? mem_data[rd_ptr] : '0;
  assign data_err_o   = data_valid_o & mem_err[rd_ptr];
  assign data_last_o  = data_valid_o & mem_last[rd_ptr];

  // Command FSM with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cmd_ready_o  <= 1'b0;
      obi_req_o    <= 1'b0;
      obi_addr_o   <= '0;
      obi_rready_o <= 1'b0;
      busy_o       <= 1'b0;
      len_q        <= '0;
      remaining    <= '0;
      rsp_cnt      <= '0;
      credit       <= '0;
    end else begin
      obi_rready_o <= 1'b1;
      credit       <= credit_nxt;
      if (push) begin
        rsp_cnt <= rsp_cnt + LenWidth'(1);
      end
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o && (cmd_len_i != '0)) begin
            state       <= ISSUE;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            obi_req_o   <= 1'b1;
            obi_addr_o  <= {cmd_addr_i[AddrWidth-1:OffWidth], OffWidth'(0)};
            len_q       <= cmd_len_i;
            remaining   <= cmd_len_i;
            rsp_cnt     <= '0;
          end
        end
        ISSUE: begin
          // A raised request is only ever lowered by its grant.
          if (grant) begin
            obi_addr_o <= obi_addr_o + AddrWidth'(BeWidth);
            remaining  <= remaining - LenWidth'(1);
            if (remaining == LenWidth'(1)) begin
              obi_req_o <= 1'b0;
              state     <= DRAIN;
            end else begin
              obi_req_o <= can_issue;
            end
          end else if (!obi_req_o) begin
            obi_req_o <= can_issue;
          end
        end
        DRAIN: begin
          if (pop && data_last_o) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response FIFO pointers; sized so the credit limit can never overflow it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      fifo_cnt <= fifo_cnt + CntWidth'(push) - CntWidth'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= obi_rdata_i;
      mem_err[wr_ptr]  <= obi_err_i;
      mem_last[wr_ptr] <= rsp_last;
    end
  end

endmodule
